board_status_mux: RTL and testbench

BOARD_STATUS_MUX -- requirements
Module: board_status_mux

---
 rtl/board_status_mux.sv | 206 ++++++++++++++++++++
 tb/tb_board_status_mux.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_status_mux.sv
// Board status viewer: buttons page through NUM_CH status channels shown on 16 LEDs and a 4-digit 7-seg.
// Define STATUS_STICKY_EN to add per-channel sticky capture, cleared by btn_clr.
module board_status_mux #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 16,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int SCAN_DIV     = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*CH_W-1:0]    ch_data,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    input  logic                      btn_clr,
    output logic [15:0]               led,
    output logic [6:0]                seg,
    output logic [3:0]                an,
    output logic                      dp,
    output logic [$clog2(NUM_CH)-1:0] page
);
    localparam int PW   = $clog2(NUM_CH);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
`ifdef STATUS_STICKY_EN
    localparam int NBTN = 3;
`else
    localparam int NBTN = 2;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [NBTN-1:0] btn_raw_s;
    logic [NBTN-1:0] sync1_q, sync2_q, db_q, db_d, press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];
    logic [PW-1:0]   page_q, page_d;
    logic [CH_W-1:0] ch_s [NUM_CH];
    logic [CH_W-1:0] disp_q, disp_d;
    logic [15:0]     disp16_s, led_q, led_d;
    logic [SC_W-1:0] scan_q, scan_d;
    logic [1:0]      digit_q, digit_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic            next_s, prev_s;

`ifdef STATUS_STICKY_EN
    logic            clr_s;
    logic [CH_W-1:0] sticky_q [NUM_CH];
    logic [CH_W-1:0] sticky_d [NUM_CH];
    assign btn_raw_s = {btn_clr, btn_prev, btn_next};
    assign clr_s     = press_q[2];
`else
    logic unused_clr_s;
    assign btn_raw_s    = {btn_prev, btn_next};
    assign unused_clr_s = btn_clr;
`endif
    assign next_s = press_q[0];
    assign prev_s = press_q[1];

    // Debounce: flip the accepted level after DEBOUNCE_CYC consecutive disagreeing cycles; rising flip emits a press
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            press_d[i]  = 1'b0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = {DB_W{1'b0}};
                    press_d[i]  = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end
        end
    end

    // Synchroniser, debounce and press-pulse state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {NBTN{1'b0}};
            sync2_q <= {NBTN{1'b0}};
            db_q    <= {NBTN{1'b0}};
            press_q <= {NBTN{1'b0}};
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= {DB_W{1'b0}};
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Page stepping; simultaneous next and prev cancel out
    always_comb begin
        page_d = page_q;
        if (next_s && !prev_s) begin
            page_d = (page_q == PW'(NUM_CH - 1)) ? PW'(0) : page_q + PW'(1);
        end else if (prev_s && !next_s) begin
            page_d = (page_q == PW'(0)) ? PW'(NUM_CH - 1) : page_q - PW'(1);
        end else begin
            page_d = page_q;
        end
    end

    // Channel unpacking and selection of the value to display
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_s[i] = ch_data[i*CH_W +: CH_W];
`ifdef STATUS_STICKY_EN
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr_s && (page_q == PW'(i))) begin
                sticky_d[i] = ch_s[i];
            end else begin
                sticky_d[i] = sticky_q[i] | ch_s[i];
            end
        end
        disp_d = sticky_q[page_q];
`else
        disp_d = ch_s[page_q];
`endif
    end

`ifdef STATUS_STICKY_EN
    // Sticky capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) sticky_q[i] <= {CH_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) sticky_q[i] <= sticky_d[i];
        end
    end
`endif

    // Digit scan and registered 7-seg / LED output values
    always_comb begin
        disp16_s = 16'(disp_q);
        led_d    = disp16_s;
        scan_d   = scan_q + SC_W'(1);
        digit_d  = digit_q;
        if (scan_q == SC_W'(SCAN_DIV - 1)) begin
            scan_d  = {SC_W{1'b0}};
            digit_d = digit_q + 2'd1;
        end else begin
            digit_d = digit_q;
        end
        an_d  = ~(4'b0001 << digit_q);
        seg_d = hex7(disp16_s[{digit_q, 2'b00} +: 4]);
        dp_d  = (digit_q == 2'(page_q)) ? 1'b0 : 1'b1;
    end

    // Page, display path and scan registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q  <= PW'(0);
            disp_q  <= {CH_W{1'b0}};
            led_q   <= 16'h0000;
            scan_q  <= {SC_W{1'b0}};
            digit_q <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            page_q  <= page_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign page = page_q;
    assign led  = led_q;
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_board_status_mux.sv
// Randomised self-checking bench for board_status_mux against a behavioural model of paging, display and scan.
module tb_board_status_mux;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 16;
    localparam int DEB    = 4;
    localparam int SDIV   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_CH*CH_W-1:0] ch_data;
    logic                   btn_next, btn_prev, btn_clr;
    logic [15:0]            led;
    logic [6:0]             seg;
    logic [3:0]             an;
    logic                   dp;
    logic [1:0]             page;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_page = 0;
    logic [15:0] model_ch [NUM_CH];
    string       lit_tbl [16];

    board_status_mux #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DEBOUNCE_CYC(DEB), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_clr(btn_clr),
        .led(led), .seg(seg), .an(an), .dp(dp), .page(page)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_ch();
        for (int i = 0; i < NUM_CH; i++) ch_data[i*CH_W +: CH_W] = model_ch[i];
    endtask

    task automatic press(input logic nx, input logic pv, input logic cl, input int hold);
        btn_next = nx; btn_prev = pv; btn_clr = cl;
        tick(hold);
        btn_next = 1'b0; btn_prev = 1'b0; btn_clr = 1'b0;
        tick(10);
    endtask

    // Active-low segment pattern built from the list of lit segment letters
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        string      s;
        logic [6:0] r;
        s = lit_tbl[n];
        r = 7'b1111111;
        for (int k = 0; k < s.len(); k++) r[s.getc(k) - 8'd97] = 1'b0;
        return r;
    endfunction

    task automatic goto_page(input int p);
        while (model_page != p) begin
            press(1'b1, 1'b0, 1'b0, 8);
            model_page = (model_page + 1) % NUM_CH;
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got=%b exp=1111", an); end
        n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL reset_led got=%h exp=0000", led); end
        n_checks++; if (page !== 2'd0) begin n_fail++; $display("FAIL reset_page got=%0d exp=0", page); end
        rst_n = 1'b1;
        tick(1);
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL first_an got=%b exp=1110", an); end
    endtask

    task automatic test_debounce();
        int changes;
        logic [1:0] prev_pg;
        press(1'b1, 1'b0, 1'b0, 3);
        n_checks++; if (page !== 2'd0) begin n_fail++; $display("FAIL short_hold got=%0d exp=0", page); end
        changes = 0;
        prev_pg = page;
        btn_next = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c == 8) btn_next = 1'b0;
            tick(1);
            if (page !== prev_pg) changes++;
            prev_pg = page;
        end
        model_page = 1;
        n_checks++; if (changes != 1) begin n_fail++; $display("FAIL long_hold_changes got=%0d exp=1", changes); end
        n_checks++; if (page !== 2'd1) begin n_fail++; $display("FAIL long_hold_page got=%0d exp=1", page); end
    endtask

    task automatic test_next_prev();
        press(1'b0, 1'b1, 1'b0, 8);
        model_page = 0;
        n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL prev_to0 got=%0d exp=%0d", page, model_page); end
        for (int k = 0; k < 5; k++) begin
            press(1'b1, 1'b0, 1'b0, 8);
            model_page = (model_page + 1) % NUM_CH;
            n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL next_seq%0d got=%0d exp=%0d", k, page, model_page); end
        end
        goto_page(0);
        press(1'b0, 1'b1, 1'b0, 8);
        model_page = NUM_CH - 1;
        n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL prev_wrap got=%0d exp=%0d", page, model_page); end
        press(1'b1, 1'b1, 1'b0, 8);
        n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL both_btn got=%0d exp=%0d", page, model_page); end
    endtask

    task automatic test_random_buttons();
        for (int k = 0; k < 12; k++) begin
            int kind, hold;
            bit longp;
            kind  = $urandom_range(0, 2);
            longp = 1'($urandom_range(0, 1));
            hold  = longp ? $urandom_range(5, 10) : $urandom_range(1, 3);
            press(kind == 0 || kind == 2, kind == 1 || kind == 2, 1'b0, hold);
            if (longp && kind == 0) model_page = (model_page + 1) % NUM_CH;
            if (longp && kind == 1) model_page = (model_page + NUM_CH - 1) % NUM_CH;
            n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL rand_btn%0d kind=%0d hold=%0d got=%0d exp=%0d", k, kind, hold, page, model_page); end
        end
    endtask

    task automatic test_datapath();
        for (int k = 0; k < 9; k++) begin
            logic [15:0] old_v;
            if (k % 3 == 2) begin
                press(1'b1, 1'b0, 1'b0, 8);
                model_page = (model_page + 1) % NUM_CH;
                n_checks++; if (led !== model_ch[model_page]) begin n_fail++; $display("FAIL page_led%0d got=%h exp=%h", k, led, model_ch[model_page]); end
            end
            old_v = model_ch[model_page];
            for (int i = 0; i < NUM_CH; i++) model_ch[i] = 16'($urandom);
            apply_ch();
            tick(1);
            n_checks++; if (led !== old_v) begin n_fail++; $display("FAIL led_lat1_%0d got=%h exp=%h", k, led, old_v); end
            tick(1);
            n_checks++; if (led !== model_ch[model_page]) begin n_fail++; $display("FAIL led_lat2_%0d got=%h exp=%h", k, led, model_ch[model_page]); end
        end
    endtask

    task automatic test_scan();
        int idx, prev_idx, run;
        bit seen_change;
        goto_page(2);
        model_ch[2] = 16'hA5F0;
        apply_ch();
        tick(3);
        n_checks++; if (led !== 16'hA5F0) begin n_fail++; $display("FAIL scan_led got=%h exp=a5f0", led); end
        prev_idx = -1; run = 0; seen_change = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            n_checks++; if (idx < 0) begin n_fail++; $display("FAIL scan_an_onehot got=%b", an); end
            if (idx >= 0) begin
                n_checks++; if (seg !== seg_of(4'(model_ch[2] >> (4 * idx)))) begin n_fail++; $display("FAIL scan_seg d%0d got=%b exp=%b", idx, seg, seg_of(4'(model_ch[2] >> (4 * idx)))); end
                n_checks++; if (dp !== (idx != model_page)) begin n_fail++; $display("FAIL scan_dp d%0d got=%b exp=%b", idx, dp, idx != model_page); end
            end
            if (idx != prev_idx) begin
                if (prev_idx >= 0) begin
                    n_checks++; if (idx != (prev_idx + 1) % 4) begin n_fail++; $display("FAIL scan_order got=%0d exp=%0d", idx, (prev_idx + 1) % 4); end
                    if (seen_change) begin
                        n_checks++; if (run != SDIV) begin n_fail++; $display("FAIL scan_hold got=%0d exp=%0d", run, SDIV); end
                    end
                    seen_change = 1'b1;
                end
                run = 1;
                prev_idx = idx;
            end else begin
                run++;
            end
        end
    endtask

`ifdef STATUS_STICKY_EN
    task automatic test_sticky();
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = 16'h0000;
        apply_ch();
        tick(2);
        for (int p = 0; p < NUM_CH; p++) begin
            press(1'b0, 1'b0, 1'b1, 8);
            press(1'b1, 1'b0, 1'b0, 8);
            model_page = (model_page + 1) % NUM_CH;
        end
        goto_page(0);
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL sticky_cleared got=%h exp=0000", led); end
        model_ch[0] = 16'h0008; model_ch[1] = 16'h0020; apply_ch();
        tick(1);
        model_ch[0] = 16'h0000; model_ch[1] = 16'h0000; apply_ch();
        tick(5);
        n_checks++; if (led !== 16'h0008) begin n_fail++; $display("FAIL sticky_hold got=%h exp=0008", led); end
        press(1'b0, 1'b0, 1'b1, 8);
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL sticky_clr got=%h exp=0000", led); end
        model_ch[0] = 16'h0008; apply_ch();
        tick(1);
        model_ch[0] = 16'h0002; apply_ch();
        press(1'b0, 1'b0, 1'b1, 8);
        n_checks++; if (led !== 16'h0002) begin n_fail++; $display("FAIL sticky_set_wins got=%h exp=0002", led); end
        model_ch[0] = 16'h0000; apply_ch();
        press(1'b1, 1'b0, 1'b0, 8);
        model_page = 1;
        n_checks++; if (led !== 16'h0020) begin n_fail++; $display("FAIL sticky_other_ch got=%h exp=0020", led); end
    endtask
`else
    task automatic test_clr_ignored();
        model_ch[model_page] = 16'h0008; apply_ch();
        tick(1);
        model_ch[model_page] = 16'h0000; apply_ch();
        tick(4);
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL live_not_sticky got=%h exp=0000", led); end
        model_ch[model_page] = 16'h1234; apply_ch();
        press(1'b0, 1'b0, 1'b1, 8);
        n_checks++; if (page !== 2'(model_page)) begin n_fail++; $display("FAIL clr_page got=%0d exp=%0d", page, model_page); end
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL clr_led got=%h exp=1234", led); end
    endtask
`endif

    task automatic test_reset_mid();
        goto_page(3);
        tick(3);
        rst_n = 1'b0;
        #1;
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_an got=%b exp=1111", an); end
        n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL mid_rst_seg got=%b exp=1111111", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dp got=%b exp=1", dp); end
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_led got=%h exp=0000", led); end
        n_checks++; if (page !== 2'd0) begin n_fail++; $display("FAIL mid_rst_page got=%0d exp=0", page); end
        model_page = 0;
        tick(1);
        rst_n = 1'b1;
        btn_next = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(DEB + 2);
        n_checks++; if (page !== 2'd0) begin n_fail++; $display("FAIL held_early got=%0d exp=0", page); end
        tick(1);
        n_checks++; if (page !== 2'd1) begin n_fail++; $display("FAIL held_press got=%0d exp=1", page); end
        btn_next = 1'b0;
        tick(12);
        n_checks++; if (page !== 2'd1) begin n_fail++; $display("FAIL held_once got=%0d exp=1", page); end
    endtask

    initial begin
        lit_tbl = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
        btn_next = 1'b0; btn_prev = 1'b0; btn_clr = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model_ch[i] = 16'h0000;
        apply_ch();
        test_reset();
        test_debounce();
        test_next_prev();
        test_random_buttons();
`ifdef STATUS_STICKY_EN
        test_sticky();
`else
        test_datapath();
        test_scan();
        test_clr_ignored();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
